multicycle_alu: RTL and testbench

//  Parametrised, registered successor to the 5-bit combinational likeALU.

---
 rtl/multicycle_alu_pkg.sv | 18 +
 rtl/multicycle_alu_mul_shift_add.sv | 55 +++++
 rtl/multicycle_alu.sv | 128 ++++++++++++
 tb/tb_multicycle_alu.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/multicycle_alu_pkg.sv
// Shared opcode encodings and FSM state type for the multi-cycle ALU.
package multicycle_alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/multicycle_alu_mul_shift_add.sv
// Unsigned shift-add multiplier: one iteration per clock for WIDTH clocks.
// product is the accumulator value after the current iteration, so it is final while last=1.
module mul_shift_add #(
    parameter int WIDTH = 5,
    parameter int CNTW  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               last,
    output logic [2*WIDTH-1:0] product
);

    logic [WIDTH-1:0]   mcand_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] acc_next;
    logic [CNTW-1:0]    cnt_reg;
    logic               busy_reg;
    logic [WIDTH:0]     step_sum;

    // Upper half accumulates partial products; lower half holds the remaining multiplier bits.
    always_comb begin
        step_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                 + (acc_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
        acc_next = {step_sum, acc_reg[WIDTH-1:1]};
    end

    assign busy    = busy_reg;
    assign last    = busy_reg && (cnt_reg == CNTW'(WIDTH-1));
    assign product = acc_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_reg <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
        end else if (load) begin
            mcand_reg <= a;
            acc_reg   <= {{WIDTH{1'b0}}, b};
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
        end else if (busy_reg) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (last) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Registered ALU with start/ready/done handshake: single-cycle logic/arith/shift ops
// and a WIDTH-cycle unsigned multiply.
module multicycle_alu
    import multicycle_alu_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int CNTW  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry,
    output logic             ovf
);

    state_t             state_reg, state_next;
    logic               accept, mul_load, mul_busy, mul_last;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH-1:0]   simple_result;
    logic               simple_carry, simple_ovf;
    logic [WIDTH:0]     add_wide, sub_wide;

    logic               done_reg, zero_reg, carry_reg, ovf_reg;
    logic [WIDTH-1:0]   result_reg, result_hi_reg;

    assign ready    = (state_reg == S_IDLE);
    assign accept   = ready && start;
    assign mul_load = accept && (op == OP_MUL);

    mul_shift_add #(.WIDTH(WIDTH), .CNTW(CNTW)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .load    (mul_load),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .last    (mul_last),
        .product (mul_product)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (mul_load) state_next = S_MUL;
            S_MUL:   if (mul_last || !mul_busy) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Simple-op datapath works straight from the inputs so the result lands on the accepting edge.
    always_comb begin
        add_wide      = {1'b0, a} + {1'b0, b};
        sub_wide      = {1'b0, a} - {1'b0, b};
        simple_result = '0;
        simple_carry  = 1'b0;
        simple_ovf    = 1'b0;
        case (op)
            OP_AND: simple_result = a & b;
            OP_OR:  simple_result = a | b;
            OP_XOR: simple_result = a ^ b;
            OP_ADD: begin
                simple_result = add_wide[WIDTH-1:0];
                simple_carry  = add_wide[WIDTH];
                simple_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (add_wide[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                simple_result = sub_wide[WIDTH-1:0];
                simple_carry  = sub_wide[WIDTH];
                simple_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (sub_wide[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLL: if (32'(b) < WIDTH) simple_result = a << b;
            OP_SRL: if (32'(b) < WIDTH) simple_result = a >> b;
            default: simple_result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_reg      <= 1'b0;
            result_reg    <= '0;
            result_hi_reg <= '0;
            zero_reg      <= 1'b0;
            carry_reg     <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (accept && (op != OP_MUL)) begin
                done_reg      <= 1'b1;
                result_reg    <= simple_result;
                result_hi_reg <= '0;
                zero_reg      <= (simple_result == '0);
                carry_reg     <= simple_carry;
                ovf_reg       <= simple_ovf;
            end else if ((state_reg == S_MUL) && mul_last) begin
                done_reg      <= 1'b1;
                result_reg    <= mul_product[WIDTH-1:0];
                result_hi_reg <= mul_product[2*WIDTH-1:WIDTH];
                zero_reg      <= (mul_product == '0);
                carry_reg     <= |mul_product[2*WIDTH-1:WIDTH];
                ovf_reg       <= 1'b0;
            end
        end
    end

    assign done      = done_reg;
    assign result    = result_reg;
    assign result_hi = result_hi_reg;
    assign zero      = zero_reg;
    assign carry     = carry_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu (WIDTH=5): vector table for simple ops plus MUL/reset sequences.
module tb_multicycle_alu;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a, b;
    logic [2:0]   op;
    logic         ready, done, zero, carry, ovf;
    logic [W-1:0] result, result_hi;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_alu #(.WIDTH(W), .CNTW(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .op        (op),
        .ready     (ready),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .carry     (carry),
        .ovf       (ovf)
    );

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [4:0] a;
        logic [4:0] b;
        logic [4:0] res;
        logic       z;
        logic       c;
        logic       v;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [4:0] r, input logic [4:0] rh,
                                 input logic z, input logic c, input logic v);
        chk({tag, ".result"}, 32'(result), 32'(r));
        chk({tag, ".result_hi"}, 32'(result_hi), 32'(rh));
        chk({tag, ".zero"}, 32'(zero), 32'(z));
        chk({tag, ".carry"}, 32'(carry), 32'(c));
        chk({tag, ".ovf"}, 32'(ovf), 32'(v));
    endtask

    task automatic run_simple(input vec_t v);
        @(negedge clk);
        start = 1'b1; op = v.op; a = v.a; b = v.b;
        @(posedge clk); #1;
        start = 1'b0;
        chk({v.name, ".done"}, 32'(done), 32'd1);
        chk({v.name, ".ready"}, 32'(ready), 32'd1);
        check_outputs(v.name, v.res, 5'b00000, v.z, v.c, v.v);
        $display("vec %s op=%b a=%b b=%b -> result=%b z=%b c=%b v=%b",
                 v.name, v.op, v.a, v.b, result, zero, carry, ovf);
    endtask

    initial begin
        vecs[0]  = '{"and_zero", 3'b000, 5'b01010, 5'b10101, 5'b00000, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{"add_carry", 3'b010, 5'b00101, 5'b11110, 5'b00011, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{"sub_borrow", 3'b011, 5'b01011, 5'b10100, 5'b10111, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{"or", 3'b001, 5'b01010, 5'b00101, 5'b01111, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{"xor", 3'b100, 5'b11111, 5'b10101, 5'b01010, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{"sll_big", 3'b101, 5'b00011, 5'b00111, 5'b00000, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{"sll_2", 3'b101, 5'b00011, 5'b00010, 5'b01100, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{"srl_3", 3'b110, 5'b11000, 5'b00011, 5'b00011, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{"add_ovf", 3'b010, 5'b01111, 5'b00001, 5'b10000, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{"sub_eq", 3'b011, 5'b00011, 5'b00011, 5'b00000, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{"srl_width", 3'b110, 5'b10000, 5'b00101, 5'b00000, 1'b1, 1'b0, 1'b0};

        reset = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", 32'(ready), 32'd1);
        chk("rst.done", 32'(done), 32'd0);
        check_outputs("rst", 5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // MUL 9*10 with an ignored ADD start during iteration 2
        @(negedge clk);
        start = 1'b1; op = 3'b111; a = 5'b01001; b = 5'b01010;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mul.ready_k0", 32'(ready), 32'd0);
        chk("mul.done_k0", 32'(done), 32'd0);
        for (int i = 1; i <= W; i++) begin
            @(posedge clk); #1;
            if (i < W) begin
                chk($sformatf("mul.ready_k%0d", i), 32'(ready), 32'd0);
                chk($sformatf("mul.done_k%0d", i), 32'(done), 32'd0);
            end
            if (i == 1) begin
                start = 1'b1; op = 3'b010; a = 5'b00001; b = 5'b00001;
            end else if (i == 2) begin
                start = 1'b0;
            end
        end
        chk("mul.done", 32'(done), 32'd1);
        chk("mul.ready_after", 32'(ready), 32'd1);
        check_outputs("mul", 5'b11010, 5'b00010, 1'b0, 1'b1, 1'b0);
        $display("mul a=01001 b=01010 -> hi=%b lo=%b carry=%b", result_hi, result, carry);
        @(posedge clk); #1;
        chk("mul.done_pulse", 32'(done), 32'd0);
        chk("mul.hold_result", 32'(result), 32'b11010);

        for (int i = 0; i < 11; i++) begin
            run_simple(vecs[i]);
        end

        // back-to-back ADD then XOR
        @(negedge clk);
        start = 1'b1; op = 3'b010; a = 5'b00110; b = 5'b00011;
        @(posedge clk); #1;
        chk("b2b.add_done", 32'(done), 32'd1);
        chk("b2b.add_result", 32'(result), 32'b01001);
        op = 3'b100; a = 5'b01100; b = 5'b00110;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b.xor_done", 32'(done), 32'd1);
        chk("b2b.xor_result", 32'(result), 32'b01010);
        $display("b2b add=01001 xor -> result=%b", result);
        @(posedge clk); #1;
        chk("b2b.done_low", 32'(done), 32'd0);

        // reset during MUL iteration 3 aborts without a done pulse
        @(negedge clk);
        start = 1'b1; op = 3'b111; a = 5'b11111; b = 5'b11111;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort.ready", 32'(ready), 32'd1);
        chk("abort.done", 32'(done), 32'd0);
        check_outputs("abort", 5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        begin
            int seen_done;
            seen_done = 0;
            repeat (W + 2) begin
                @(posedge clk); #1;
                if (done) seen_done++;
            end
            chk("abort.no_done", 32'(seen_done), 32'd0);
        end
        $display("abort mul at iteration 3 -> ready=%b result=%b", ready, result);

        run_simple(vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
